// File: rtl/apb2spi_xfer_ctrl.sv
// APB master sequencer for a SPI peripheral: write TX word, poll status until idle, read RX word.
// Optional poll timeout is compiled in with `define APB2SPI_XFER_TIMEOUT_EN.
module apb2spi_xfer_ctrl #(
  parameter logic [31:0] TX_ADDR   = 32'h0000_0000,
  parameter logic [31:0] STAT_ADDR = 32'h0000_0004,
  parameter logic [31:0] RX_ADDR   = 32'h0000_0008,
  parameter int          BUSY_BIT  = 0,
  parameter int          POLL_MAX  = 255
) (
  input  logic        pi_clk,
  input  logic        pi_rst,
  input  logic [1:0]  pi_req,
  input  logic [63:0] pi_req_data,
  output logic [1:0]  po_done,
  output logic [31:0] po_rdata,
  output logic        po_err,
  output logic [31:0] po_paddr,
  output logic        po_psel,
  output logic        po_penable,
  output logic        po_pwrite,
  output logic [31:0] po_pwdata,
  output logic [3:0]  po_pstrb,
  input  logic        pi_pready,
  input  logic [31:0] pi_prdata,
  input  logic        pi_pslverr
);

  typedef enum logic [2:0] {IDLE, WR_S, WR_A, PL_S, PL_A, RD_S, RD_A, DONE} state_t;

  if (POLL_MAX < 1 || POLL_MAX > 255) begin : g_bad_poll_max
    $error("POLL_MAX must be in 1..255");
  end

  state_t      state;
  state_t      state_nxt;
  logic        grant;
  logic        last_grant;
  logic        err;
  logic [31:0] tx_word;
  logic [31:0] rx_word;
  logic        pick;
  logic        start;
  logic        in_access;
  logic        busy;
  logic        timeout;
  logic        abort;

  // On a tie the requester that was not served last wins.
  assign pick      = (pi_req == 2'b11) ? ~last_grant : pi_req[1];
  assign start     = (state == IDLE) && (|pi_req);
  assign in_access = (state == WR_A) || (state == PL_A) || (state == RD_A);
  assign busy      = pi_prdata[BUSY_BIT];
  assign abort     = in_access && pi_pready && (pi_pslverr || timeout);

`ifdef APB2SPI_XFER_TIMEOUT_EN
  logic [7:0] poll_cnt;

  always_ff @(posedge pi_clk or posedge pi_rst) begin
    if (pi_rst) begin
      poll_cnt <= '0;
    end else if (state == WR_A && pi_pready) begin
      poll_cnt <= '0;
    end else if (state == PL_A && pi_pready) begin
      poll_cnt <= poll_cnt + 8'd1;
    end
  end

  // Compare against the count this completing poll brings it to.
  assign timeout = (state == PL_A) && pi_pready && busy && (poll_cnt == 8'(POLL_MAX - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge pi_clk or posedge pi_rst) begin
    if (pi_rst) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      err        <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start) begin
        grant      <= pick;
        last_grant <= pick;
        err        <= 1'b0;
      end else if (abort) begin
        err <= 1'b1;
      end
    end
  end

  // Data holding registers carry no reset; every output that shows them is state-gated.
  always_ff @(posedge pi_clk) begin
    if (start) begin
      tx_word <= pick ? pi_req_data[63:32] : pi_req_data[31:0];
    end
    if (state == RD_A && pi_pready) begin
      rx_word <= pi_prdata;
    end
  end

  always_comb begin
    state_nxt  = state;
    po_psel    = 1'b0;
    po_penable = 1'b0;
    po_pwrite  = 1'b0;
    po_paddr   = '0;
    po_pwdata  = '0;
    po_pstrb   = '0;
    po_done    = '0;
    po_err     = 1'b0;
    po_rdata   = '0;
    case (state)
      IDLE: if (|pi_req) state_nxt = WR_S;
      WR_S, WR_A: begin
        po_psel    = 1'b1;
        po_penable = (state == WR_A);
        po_pwrite  = 1'b1;
        po_paddr   = TX_ADDR;
        po_pwdata  = tx_word;
        po_pstrb   = 4'hF;
        if (state == WR_S) state_nxt = WR_A;
        else if (pi_pready) state_nxt = pi_pslverr ? DONE : PL_S;
      end
      PL_S, PL_A: begin
        po_psel    = 1'b1;
        po_penable = (state == PL_A);
        po_paddr   = STAT_ADDR;
        if (state == PL_S) state_nxt = PL_A;
        else if (pi_pready) begin
          if (abort) state_nxt = DONE;
          else if (busy) state_nxt = PL_S;
          else state_nxt = RD_S;
        end
      end
      RD_S, RD_A: begin
        po_psel    = 1'b1;
        po_penable = (state == RD_A);
        po_paddr   = RX_ADDR;
        if (state == RD_S) state_nxt = RD_A;
        else if (pi_pready) state_nxt = DONE;
      end
      DONE: begin
        po_done   = grant ? 2'b10 : 2'b01;
        po_err    = err;
        po_rdata  = err ? 32'h0 : rx_word;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_apb2spi_xfer_ctrl.sv
// Testbench for apb2spi_xfer_ctrl: APB slave responder plus transaction-level reference model.
module tb_apb2spi_xfer_ctrl;

`ifdef APB2SPI_XFER_TIMEOUT_EN
  localparam int PM = 4;
  localparam bit TO_EN = 1'b1;
`else
  localparam int PM = 255;
  localparam bit TO_EN = 1'b0;
`endif
  localparam logic [31:0] A_TX = 32'h0, A_ST = 32'h4, A_RX = 32'h8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req = '0;
  logic [63:0] req_data = '0;
  logic [1:0]  done;
  logic [31:0] rdata;
  logic        err;
  logic [31:0] paddr;
  logic        psel, penable, pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        pready = 1'b0;
  logic [31:0] prdata = '0;
  logic        pslverr = 1'b0;

  int tests = 0;
  int fails = 0;
  logic rr_last = 1'b1;

  apb2spi_xfer_ctrl #(.POLL_MAX(PM)) dut (
    .pi_clk(clk), .pi_rst(rst), .pi_req(req), .pi_req_data(req_data),
    .po_done(done), .po_rdata(rdata), .po_err(err),
    .po_paddr(paddr), .po_psel(psel), .po_penable(penable), .po_pwrite(pwrite),
    .po_pwdata(pwdata), .po_pstrb(pstrb),
    .pi_pready(pready), .pi_prdata(prdata), .pi_pslverr(pslverr)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] all_outs();
    return {done, rdata, err, paddr, psel, penable, pwrite, pwdata, pstrb};
  endfunction

  // One transaction: model builds the expected access list, slave replays responses.
  task automatic run_txn(input string tag, input logic [1:0] r, input logic [63:0] d,
                         input int nbusy, input int wt, input int err_at,
                         input logic [31:0] rx, input int drop_at);
    logic [31:0] ea[16];
    logic        ew[16];
    logic [31:0] ed[16];
    logic [31:0] rsp[16];
    logic        rer[16];
    int n = 0, np, k = 0, waited = 0, cyc = 0, lat;
    logic g, to = 1'b0, exp_err, seen = 1'b0;
    logic [31:0] word, exp_rd;
    logic [68:0] snap = '0;

    g = (r == 2'b11) ? ~rr_last : r[1];
    rr_last = g;
    word = g ? d[63:32] : d[31:0];
    ea[n] = A_TX; ew[n] = 1'b1; ed[n] = word; rsp[n] = $urandom; rer[n] = (err_at == 1); n++;
    if (err_at != 1) begin
      np = nbusy + 1;
      if (TO_EN && nbusy >= PM) begin np = PM; to = 1'b1; end
      for (int i = 0; i < np && n < 15; i++) begin
        ea[n] = A_ST; ew[n] = 1'b0; ed[n] = '0;
        rsp[n] = ($urandom & ~32'h1) | ((i < nbusy) ? 32'h1 : 32'h0);
        rer[n] = (err_at == 2 && i == 0);
        n++;
        if (err_at == 2) break;
      end
      if (err_at != 2 && !to) begin
        ea[n] = A_RX; ew[n] = 1'b0; ed[n] = '0; rsp[n] = rx; rer[n] = (err_at == 3); n++;
      end
    end
    exp_err = (err_at != 0) || to;
    exp_rd  = exp_err ? 32'h0 : rx;
    lat = 1 + n * (2 + wt);

    req = r;
    req_data = d;
    while (!seen && cyc < lat + 50) begin
      @(negedge clk);
      cyc++;
      if (cyc == drop_at) req = 2'b00;
      pslverr = 1'b0;
      if (done != 2'b00) begin
        seen = 1'b1;
        pready = 1'b0;
        chk({tag, "_done"}, done, g ? 2'b10 : 2'b01);
        chk({tag, "_rdata"}, rdata, exp_rd);
        chk({tag, "_err"}, err, exp_err);
        chk({tag, "_naccess"}, k, n);
        chk({tag, "_latency"}, cyc, lat);
        chk({tag, "_apb_idle"}, {psel, penable, pwrite}, 3'b000);
      end else if (psel && !penable) begin
        snap = {paddr, pwrite, pwdata, pstrb};
        waited = 0;
        pready = 1'b0;
      end else if (psel && penable) begin
        chk({tag, "_stable"}, {paddr, pwrite, pwdata, pstrb}, snap);
        if (waited >= wt) begin
          pready = 1'b1;
          chk({tag, "_in_range"}, k < n, 1'b1);
          if (k < n) begin
            chk({tag, "_access"}, {paddr, pwrite, pwdata, pstrb},
                {ea[k], ew[k], ed[k], ew[k] ? 4'hF : 4'h0});
            prdata = rsp[k];
            pslverr = rer[k];
          end else begin
            prdata = '0;
          end
          k++;
        end else begin
          waited++;
          pready = 1'b0;
        end
      end else begin
        pready = 1'b0;
      end
    end
    chk({tag, "_done_seen"}, seen, 1'b1);
    @(negedge clk);
    chk({tag, "_pulse_width"}, done, 2'b00);
    req = 2'b00;
  endtask

  initial begin
    logic found;
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs", all_outs(), '0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_outs", all_outs(), '0);

    run_txn("basic", 2'b01, {32'h1111_2222, 32'hA5A5_0001}, 0, 0, 0, 32'h0000_00C3, 0);
    run_txn("wr_slverr", 2'b10, {$urandom, $urandom}, 0, 0, 1, $urandom, 0);
    run_txn("busy_wait", 2'b01, {$urandom, $urandom}, 3, 2, 0, 32'hDEAD_BEEF, 0);
    run_txn("st_slverr", 2'b01, {$urandom, $urandom}, 2, 1, 2, $urandom, 0);
    run_txn("rx_slverr", 2'b10, {$urandom, $urandom}, 1, 0, 3, $urandom, 0);

    // Reset in the middle of the write access phase
    req = 2'b01;
    req_data = {$urandom, $urandom};
    pready = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      found = psel && penable && pwrite;
    end
    chk("rst_reached_wr_a", found, 1'b1);
    rst = 1'b1;
    #1;
    chk("rst_async_outs", all_outs(), '0);
    req = 2'b00;
    rr_last = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_release_outs", all_outs(), '0);
    end

    for (int i = 0; i < 3; i++) begin
      run_txn("rr_tie", 2'b11, {$urandom, $urandom}, i, 0, 0, $urandom, 0);
    end

    for (int t = 0; t < 24; t++) begin
      run_txn("rand", 2'($urandom_range(1, 3)), {$urandom, $urandom},
              $urandom_range(0, 3), $urandom_range(0, 2),
              ($urandom_range(0, 5) <= 3) ? 0 : $urandom_range(1, 3),
              $urandom, ($urandom_range(0, 3) == 0) ? 3 : 0);
    end

`ifdef APB2SPI_XFER_TIMEOUT_EN
    run_txn("timeout", 2'b01, {$urandom, $urandom}, 20, 1, 0, $urandom, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/apb2spi_xfer_ctrl.md
APB2SPI_XFER_CTRL -- requirements
Module: apb2spi_xfer_ctrl

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- TX_ADDR, 32'h0000_0000, SPI TX data register address.
- STAT_ADDR, 32'h0000_0004, SPI status register address.
- RX_ADDR, 32'h0000_0008, SPI RX data register address.
- BUSY_BIT, 0, status bit index; 1 = transfer in progress.
- POLL_MAX, 255, maximum status polls before timeout, 1..255.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- pi_clk, in, 1, sole clock, rising edge.
- pi_rst, in, 1, asynchronous active-high reset.
- pi_req, in, 2, per-requester transfer request; held high until done.
- pi_req_data, in, 64, TX word per requester: [31:0] for requester 0, [63:32] for requester 1.
- po_done, out, 2, one-hot single-cycle completion pulse to the granted requester.
- po_rdata, out, 32, RX word; valid during the po_done cycle.
- po_err, out, 1, error flag; valid during the po_done cycle.
- po_paddr, out, 32, APB master address.
- po_psel, out, 1, APB select.
- po_penable, out, 1, APB enable.
- po_pwrite, out, 1, APB write strobe.
- po_pwdata, out, 32, APB write data.
- po_pstrb, out, 4, APB byte strobes.
- pi_pready, in, 1, APB ready.
- pi_prdata, in, 32, APB read data.
- pi_pslverr, in, 1, APB slave error.

Function
REQ-003 FSM states SHALL be IDLE, WR_S, WR_A, PL_S, PL_A, RD_S, RD_A, DONE. Every *_S state lasts one cycle (psel=1, penable=0). Every *_A state holds (psel=1, penable=1) until pi_pready=1.
REQ-004 In IDLE, when any pi_req bit is high, the block SHALL grant round-robin: on a tie, the requester not granted last wins. It SHALL latch the grant index and the matching TX word, then go to WR_S.
REQ-005 WR_S/WR_A SHALL write the TX word to TX_ADDR with pwrite=1 and pstrb=4'hF.
REQ-006 PL_S/PL_A SHALL read STAT_ADDR. On completion, prdata[BUSY_BIT]=1 SHALL return to PL_S; =0 SHALL go to RD_S.
REQ-007 RD_S/RD_A SHALL read RX_ADDR and latch pi_prdata into po_rdata.
REQ-008 If pi_pslverr=1 in any access cycle with pi_pready=1, the block SHALL abort to DONE with po_err=1 and po_rdata=0.
REQ-009 DONE SHALL last one cycle: po_done[grant]=1, then return to IDLE. New arbitration is possible in the next cycle.
REQ-010 Minimum latency, from pi_req high in IDLE to the po_done pulse, with zero-wait slave and a single non-busy poll, SHALL be 7 cycles.
REQ-011 Address, pwrite and pwdata SHALL be stable from each *_S through the end of its *_A. Outside a transfer, psel, penable and pwrite SHALL be 0.
REQ-012 Deasserting pi_req mid-transaction SHALL NOT abort it. The completion is still signalled.
REQ-013 The grant SHALL never change between IDLE exit and DONE. The other requester waits.

Reset
REQ-014 pi_rst=1 SHALL immediately force IDLE, all outputs 0 (including po_paddr and po_pstrb), and the round-robin pointer to "requester 1 last". This holds even mid-APB-access. No po_done is issued for the aborted transaction.

Configuration
REQ-015 With APB2SPI_XFER_TIMEOUT_EN defined, a poll counter SHALL:
- clear on WR_A exit;
- increment on each PL_A completion.
When a busy poll completes and the count equals POLL_MAX, the block SHALL go to DONE with po_err=1 and po_rdata=0.
Without the macro, polling SHALL continue indefinitely and no counter logic is present.

Verification
REQ-016 Reset mid-WR_A (psel=penable=1), then release -> next cycle all APB outputs 0 and state IDLE; no po_done pulse.
REQ-017 pi_req=2'b01, data 32'hA5A5_0001, zero-wait slave, status 0, RX 32'h0000_00C3 -> write 32'hA5A5_0001 to 0x0, read 0x4, read 0x8; po_done=2'b01 with po_rdata=32'h0000_00C3 at cycle 7.
REQ-018 pi_req=2'b11 held for three back-to-back transactions after reset -> grant order 0, 1, 0.
REQ-019 pslverr=1 on the TX write -> no status or RX access; po_done pulse with po_err=1 and po_rdata=0.
REQ-020 Status busy for 3 polls, pready low for 2 cycles on each access -> exactly 4 status reads; APB signals stable during waits; correct po_rdata returned.
REQ-021 With APB2SPI_XFER_TIMEOUT_EN and POLL_MAX=4, status stuck busy -> exactly 4 polls, then po_err=1 and no RX read.
